// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with registered read port, standard or FWFT read.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH    = 64,
  parameter int DATA_DEPTH    = 9,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (1 << DATA_DEPTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DATA_DEPTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [DATA_DEPTH:0]   c_CAP     = (DATA_DEPTH+1)'(1 << DATA_DEPTH);
  localparam logic [DATA_DEPTH:0]   c_AFULL   = (DATA_DEPTH+1)'(AFULL_THRESH);
  localparam logic [DATA_DEPTH:0]   c_AEMPTY  = (DATA_DEPTH+1)'(AEMPTY_THRESH);
  localparam logic [DATA_DEPTH:0]   c_CNT_ONE = (DATA_DEPTH+1)'(1);
  localparam logic [DATA_DEPTH-1:0] c_PTR_ONE = DATA_DEPTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [0:(1 << DATA_DEPTH)-1];
  logic [DATA_DEPTH-1:0] r_wptr;
  logic [DATA_DEPTH-1:0] r_rptr;
  logic [DATA_DEPTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_vld;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_fetch;
  logic                  w_vld_nxt;
  logic                  w_empty_nxt;
  logic [DATA_DEPTH:0]   w_count_nxt;

  // Acceptance uses only the pre-edge flags: no full/empty bypass.
  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // count includes the head word, so RAM occupancy is count minus r_vld.
      logic w_ram_nonempty;
      assign w_ram_nonempty = (r_count != {{DATA_DEPTH{1'b0}}, r_vld});
      assign w_fetch        = w_ram_nonempty && (!r_vld || w_rd_acc);
      assign w_vld_nxt      = w_fetch || (r_vld && !w_rd_acc);
      assign w_empty_nxt    = !w_vld_nxt;
    end else begin : g_std
      assign w_fetch     = w_rd_acc;
      assign w_vld_nxt   = w_rd_acc;
      assign w_empty_nxt = (w_count_nxt == '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_fetch) begin
      r_rdata <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_fetch) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_CAP);
      r_empty <= w_empty_nxt;
      r_vld   <= w_vld_nxt;
      // A new offence wins over a coincident clear.
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (rd_en && r_empty) begin
        r_unf <= 1'b1;
      end else if (clr_err) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign rvalid       = r_vld;
  assign rdata        = r_rdata;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  assign almost_full  = (r_count >= c_AFULL);
  assign almost_empty = (r_count <= c_AEMPTY);

endmodule
`default_nettype wire
